frame_serializer: RTL
=====================

// Module: frame_serializer
// PURPOSE
//  Upstream stage of the serial command link. Accepts parallel words {command, data[4:0]} over a valid/ready handshake.
//  Buffers them in a small FIFO and emits each word as a 6-bit serial frame on ser_data_o / data_val_o.
//  Frame format, one bit per clk_i: data[4], data[3], data[2], data[1], data[0], command.
//  data_val_o pulses only with the first bit, which is the start strobe the receiving deserializer samples.
// PARAMETERS
//  DATA_W      5   payload bits per frame; the frame is DATA_W+1 bits long
//  FIFO_DEPTH  4   word buffer depth; must be a power of two and >= 2
//  GAP_CYCLES  0   forced idle cycles between consecutive frames (0 = back-to-back)
// PORTS
//  clk_i         in   1                        clock; all logic on posedge
//  rst_i         in   1                        reset, asynchronous, active-high
//  data_i        in   DATA_W                   payload word
//  command_i     in   1                        command flag, sent as the last frame bit
//  valid_i       in   1                        data_i/command_i valid
//  ready_o       out  1                        FIFO can accept a word
//  ser_data_o    out  1                        serial bit, MSB first
//  data_val_o    out  1                        start-of-frame strobe, high in bit-0 cycle only
//  busy_o        out  1                        frame in progress, or in GAP
//  fifo_level_o  out  $clog2(FIFO_DEPTH)+1     words held in the FIFO
// BEHAVIOUR
//  Reset: all outputs are registered and go to 0 immediately.
//   - Exception: ready_o is 1 after reset.
//   - FIFO is emptied and the FSM returns to IDLE.
//   - A frame cut off by reset is discarded and never resumed; the deserializer shares rst_i.
//  Push: when valid_i && ready_o at a posedge, the word is written.
//   - ready_o = !full, registered.
//   - No push while full, even if a pop happens in the same cycle.
//   - Push and pop in the same cycle are both honoured; the level is unchanged.
//  FSM states: IDLE, SEND, GAP.
//   - IDLE: if the FIFO is non-empty, pop the head into a 6-bit shift register.
//     Set data_val_o=1, ser_data_o=data[4], bit counter=5, go to SEND.
//     Otherwise ser_data_o=0 and data_val_o=0.
//   - SEND: data_val_o=0. Shift out one bit per cycle and decrement the counter.
//   - SEND, last bit (command) on the wire:
//     if GAP_CYCLES>0, go to GAP;
//     else if the FIFO is non-empty, pop and start the next frame on the next cycle;
//     else go to IDLE.
//   - GAP: ser_data_o=0 and data_val_o=0 for GAP_CYCLES cycles, then behave as IDLE.
//  Latency: word pushed at edge k into an empty, idle block gives data_val_o=1 in the cycle following edge k+1.
//  Frame period = DATA_W+1+GAP_CYCLES cycles. data_val_o is never high outside a frame's first bit.
//  No bypass path: a push into an empty FIFO is always seen by the FSM one cycle later.
//  Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The level counter is one bit wider so full is distinguishable.
//  busy_o = (state != IDLE).
// STRUCTURE
//  serdes_pkg (shared with the deserializer):
//   - FRAME_DATA_W = 5
//   - FRAME_BITS = FRAME_DATA_W+1
//   - typedef struct packed {logic command; logic [FRAME_DATA_W-1:0] data;} frame_t
//   - typedef enum logic [1:0] {IDLE, SEND, GAP} ser_state_e
//  Sub-module frame_fifo: synchronous frame_t FIFO with push/pop/full/empty/level.
//   This block instantiates it and adds the FSM, shift register and counters.
// TESTING
//  1. Push data=5'b10110, cmd=1 -> ser_data_o = 1,0,1,1,0,1 over 6 cycles; data_val_o high only in the first cycle; busy_o then 0.
//  2. Push 5'h1F/cmd0 then 5'h00/cmd1 back-to-back -> 12 contiguous bits 111110 000001, data_val_o pulses 6 cycles apart.
//  3. Push 5 words while serializing, GAP_CYCLES=0, FIFO_DEPTH=4 -> ready_o falls at level 4 and the 5th push stalls.
//     After the first pop, ready_o returns; all frames arrive in order.
//  4. Assert rst_i at bit 3 of a frame -> outputs 0 asynchronously, level 0; after release, no residual bits and the next push frames normally.
//  5. GAP_CYCLES=2, two queued words -> 2 idle zero cycles between frames; data_val_o pulses 8 cycles apart.
//  6. Loopback into the deserializer with 32 random words -> data_o/command_o match every pushed word in order.

Source files
------------

// File: rtl/serdes_pkg.sv
// Types and constants shared by the serial command link serializer and deserializer.
package serdes_pkg;

  localparam int FRAME_DATA_W = 5;
  localparam int FRAME_BITS   = FRAME_DATA_W + 1;

  typedef struct packed {
    logic                    command;
    logic [FRAME_DATA_W-1:0] data;
  } frame_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } ser_state_e;

endpackage

// File: rtl/frame_fifo.sv
// Synchronous frame_t FIFO; full/empty are registered so the writer sees a glitch-free ready.
module frame_fifo
  import serdes_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  frame_t                   wr_data,
  output frame_t                   rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  frame_t             mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LVL_W-1:0]   level_r;
  logic [LVL_W-1:0]   level_s;
  logic               full_r;
  logic               empty_r;
  logic               do_push_s;
  logic               do_pop_s;

  assign do_push_s = push & ~full_r;
  assign do_pop_s  = pop & ~empty_r;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_s = level_r;
    case ({do_push_s, do_pop_s})
      2'b10:   level_s = level_r + LVL_W'(1);
      2'b01:   level_s = level_r - LVL_W'(1);
      default: level_s = level_r;
    endcase
  end

  // Pointer, level and flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      level_r <= level_s;
      full_r  <= (level_s == LVL_W'(DEPTH));
      empty_r <= (level_s == LVL_W'(0));
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;
  assign level   = level_r;

endmodule

// File: rtl/frame_serializer.sv
// Buffers {command, data} words and sends each as a serial frame, data MSB first, command last,
// with a start strobe on the first bit.
module frame_serializer
  import serdes_pkg::*;
#(
  parameter int DATA_W     = FRAME_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          command_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          ser_data_o,
  output logic                          data_val_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  ser_state_e        state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [DATA_W:0]   shift_r, shift_s;
  logic [GAP_W-1:0]  gap_r, gap_s;
  logic              ser_r, ser_s;
  logic              dv_r, dv_s;
  logic              busy_r;
  logic              push_s, pop_s, launch_s;
  logic              full_s, empty_s;
  frame_t            wr_frame_s, rd_frame_s;

  assign push_s             = valid_i & ~full_s;
  assign wr_frame_s.command = command_i;
  assign wr_frame_s.data    = data_i;

  frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (wr_frame_s),
    .rd_data (rd_frame_s),
    .full    (full_s),
    .empty   (empty_s),
    .level   (fifo_level_o)
  );

  // Next-state and next-output logic; launch_s starts a frame from the FIFO head.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    shift_s  = shift_r;
    gap_s    = gap_r;
    ser_s    = 1'b0;
    dv_s     = 1'b0;
    launch_s = 1'b0;
    pop_s    = 1'b0;
    case (state_r)
      IDLE: launch_s = ~empty_s;
      SEND: begin
        if (cnt_r != '0) begin
          ser_s   = shift_r[DATA_W];
          shift_s = {shift_r[DATA_W-1:0], 1'b0};
          cnt_s   = cnt_r - CNT_W'(1);
        end else if (GAP_CYCLES > 0) begin
          state_s = GAP;
          gap_s   = GAP_W'(GAP_CYCLES - 1);
        end else begin
          launch_s = ~empty_s;
          state_s  = IDLE;
        end
      end
      GAP: begin
        if (gap_r != '0) begin
          gap_s = gap_r - GAP_W'(1);
        end else begin
          launch_s = ~empty_s;
          state_s  = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
    // The first data bit goes straight to the wire; the rest queue up behind it.
    if (launch_s) begin
      pop_s   = 1'b1;
      state_s = SEND;
      ser_s   = rd_frame_s.data[DATA_W-1];
      dv_s    = 1'b1;
      shift_s = {rd_frame_s.data[DATA_W-2:0], rd_frame_s.command, 1'b0};
      cnt_s   = CNT_W'(DATA_W);
    end else begin
      pop_s = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      shift_r <= '0;
      gap_r   <= '0;
      ser_r   <= 1'b0;
      dv_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      shift_r <= shift_s;
      gap_r   <= gap_s;
      ser_r   <= ser_s;
      dv_r    <= dv_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  assign ready_o    = ~full_s;
  assign ser_data_o = ser_r;
  assign data_val_o = dv_r;
  assign busy_o     = busy_r;

endmodule
